// File: rtl/pc_pkg.sv
// Shared types and helpers for the program sequencer.
// Op encoding and offset sign extension.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'b000,
    PC_INC  = 3'b001,
    PC_JMP  = 3'b010,
    PC_BR   = 3'b011,
    PC_CALL = 3'b100,
    PC_RET  = 3'b101
  } pc_op_t;

  localparam int PC_MAX_W = 64;

  // Replicate bit w-1 of off into every bit above it.
  function automatic logic [PC_MAX_W-1:0] sext_offset(
    input logic [PC_MAX_W-1:0] off,
    input int                  w
  );
    logic [PC_MAX_W-1:0] hi;
    logic                sgn;
    hi  = {PC_MAX_W{1'b1}} << w;
    sgn = |(off & (PC_MAX_W'(1) << (w - 1)));
    return sgn ? (off | hi) : (off & ~hi);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for the program sequencer.
// Push when full and pop when empty are ignored.
module ret_stack
  import pc_pkg::*;
#(
  parameter  int BITS  = 8,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [BITS-1:0] wdata,
  output logic [BITS-1:0] top,
  output logic [DW-1:0]   depth,
  output logic            full,
  output logic            empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign wr_idx = AW'(depth);
  assign rd_idx = AW'(depth - DW'(1));
  assign full   = (depth == DW'(DEPTH));
  assign empty  = (depth == '0);
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[wr_idx] <= wdata;
      depth       <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Next-fetch-address sequencer with call/return stack.
// Holds count and the sticky fault flag.
module program_sequencer
  import pc_pkg::*;
#(
  parameter  int            BITS      = 8,
  parameter  int            OFFSET_W  = 3,
  parameter  int            DEPTH     = 4,
  parameter  logic [BITS-1:0] RESET_VEC = '0,
  localparam int            DW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  pc_op_t              op,
  input  logic [BITS-1:0]     target,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                cond,
  input  logic                clr_fault,
  output logic [BITS-1:0]     count,
  output logic [DW-1:0]       depth,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                fault
);

  logic [BITS-1:0] nxt;
  logic [BITS-1:0] inc;
  logic [BITS-1:0] br;
  logic [BITS-1:0] top;
  logic            push;
  logic            pop;
  logic            ev;

  assign inc = count + BITS'(1);
  assign br  = count +
    BITS'(sext_offset(PC_MAX_W'(offset), OFFSET_W));

  always_comb begin
    nxt  = count;
    push = 1'b0;
    pop  = 1'b0;
    ev   = 1'b0;
    if (en) begin
      unique case (op)
        PC_HOLD: nxt = count;
        PC_INC:  nxt = inc;
        PC_JMP:  nxt = target;
        PC_BR:   nxt = cond ? br : inc;
        PC_CALL: begin
          if (stack_full) begin
            nxt = inc;
            ev  = 1'b1;
          end else begin
            nxt  = target;
            push = 1'b1;
          end
        end
        PC_RET: begin
          if (stack_empty) begin
            nxt = inc;
            ev  = 1'b1;
          end else begin
            nxt = top;
            pop = 1'b1;
          end
        end
        default: ev = 1'b1;
      endcase
    end
  end

  ret_stack #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (inc),
    .top   (top),
    .depth (depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // A new fault event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VEC;
      fault <= 1'b0;
    end else begin
      count <= nxt;
      if (ev) begin
        fault <= 1'b1;
      end else if (clr_fault) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer.
// Queue-based model predicts count, depth and fault.
module tb_program_sequencer;
  import pc_pkg::*;

  localparam int RV = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  pc_op_t     op = PC_HOLD;
  logic [7:0] target = '0;
  logic [2:0] offset = '0;
  logic       cond = 1'b0;
  logic       clr_fault = 1'b0;
  logic [7:0] count;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;

  program_sequencer #(
    .BITS      (8),
    .OFFSET_W  (3),
    .DEPTH     (4),
    .RESET_VEC (8'h10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .cond        (cond),
    .clr_fault   (clr_fault),
    .count       (count),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int dep;
    int flt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  int m_count = RV;
  int m_stk[$];
  int m_fault = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".count"}, int'(count), e.cnt);
    chk({tag, ".depth"}, int'(depth), e.dep);
    chk({tag, ".fault"}, int'(fault), e.flt);
    chk({tag, ".full"}, int'(stack_full), int'(e.dep == 4));
    chk({tag, ".empty"}, int'(stack_empty), int'(e.dep == 0));
  endtask

  task automatic step(input bit e, input int o, input int t,
                      input int off, input bit c, input bit clr);
    int   nc;
    int   so;
    bit   ev;
    exp_t x;
    @(negedge clk);
    en        = e;
    op        = pc_op_t'(3'(o));
    target    = 8'(t);
    offset    = 3'(off);
    cond      = c;
    clr_fault = clr;
    nc = m_count;
    ev = 0;
    so = (off >= 4) ? off - 8 : off;
    if (e) begin
      case (o)
        0: nc = m_count;
        1: nc = (m_count + 1) % 256;
        2: nc = t;
        3: nc = c ? (m_count + so + 256) % 256 : (m_count + 1) % 256;
        4: begin
          if (m_stk.size() < 4) begin
            m_stk.push_back((m_count + 1) % 256);
            nc = t;
          end else begin
            nc = (m_count + 1) % 256;
            ev = 1;
          end
        end
        5: begin
          if (m_stk.size() > 0) nc = m_stk.pop_back();
          else begin
            nc = (m_count + 1) % 256;
            ev = 1;
          end
        end
        default: ev = 1;
      endcase
    end
    if (ev) m_fault = 1;
    else if (clr) m_fault = 0;
    m_count = nc;
    x.cnt = m_count;
    x.dep = m_stk.size();
    x.flt = m_fault;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    exp_t x;
    @(negedge clk);
    #2;
    reset = 1'b1;
    m_count = RV;
    m_stk.delete();
    m_fault = 0;
    x.cnt = RV;
    x.dep = 0;
    x.flt = 0;
    #1;
    chk_all("reset_async", x);
    en = 1'b0;
    clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("cycle", e);
      end
    end
  end

  initial begin : stim
    int o;
    do_reset();
    step(1, 2, 8'h30, 0, 0, 0);
    step(1, 4, 8'h60, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0);
    step(1, 2, 8'h37, 0, 0, 0);
    do_reset();
    step(1, 2, 8'hFE, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 8'h02, 0, 0, 0);
    step(1, 3, 0, 3'b101, 1, 0);
    step(1, 2, 8'h02, 0, 0, 0);
    step(1, 3, 0, 3'b101, 0, 0);
    step(1, 2, 8'h7E, 0, 0, 0);
    step(1, 3, 0, 3'b011, 1, 0);
    step(1, 2, 8'h05, 0, 0, 0);
    step(1, 4, 8'h40, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    step(1, 4, 8'h50, 0, 0, 0);
    step(1, 4, 8'h60, 0, 0, 0);
    step(1, 4, 8'h70, 0, 0, 0);
    step(1, 4, 8'h20, 0, 0, 0);
    step(1, 4, 8'h99, 0, 0, 0);
    repeat (5) step(1, 5, 0, 0, 0, 0);
    repeat (3) step(0, 2, 8'hAA, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 7, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      o = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 5);
      step($urandom_range(0, 4) != 0, o, $urandom_range(0, 255),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 5) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised program counter for the 8-bit core and its wider derivatives. It replaces the fixed-width counter with a sequencer that selects the next fetch address per cycle: hold, increment, absolute jump, conditional relative branch, and call/return through an internal return-address stack of configurable depth. It sits between the decoder (which drives `op`, `target`, `offset`, `cond`) and instruction memory (which consumes `count`).

## Interface
- `BITS`, 8, address width of `count`, `target` and stack entries.
- `OFFSET_W`, 3, width of the signed branch offset; legal range 2..`BITS`.
- `DEPTH`, 4, return-stack entries; must be ≥1.
- `RESET_VEC`, 0, value of `count` after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  advance enable; 0 freezes all state.
- `op`  in  3  operation code, type `pc_op_t`.
- `target`  in  `BITS`  absolute destination for JMP and CALL.
- `offset`  in  `OFFSET_W`  signed two's-complement branch offset.
- `cond`  in  1  branch-taken qualifier for BR.
- `clr_fault`  in  1  clears sticky `fault`.
- `count`  out  `BITS`  current fetch address.
- `depth`  out  `$clog2(DEPTH+1)`  number of occupied stack entries.
- `stack_full`  out  1  `depth == DEPTH`.
- `stack_empty`  out  1  `depth == 0`.
- `fault`  out  1  sticky overflow, underflow or illegal-op flag.

## Operation
- `en=0`: `count`, stack, `depth` and `fault` hold regardless of `op`. `clr_fault` still acts.
- `en=1`, by `op`:
  - HOLD (000): `count` unchanged.
  - INC (001): `count <= count+1`, modulo 2^`BITS`.
  - JMP (010): `count <= target`.
  - BR (011): `cond=1` → `count <= count + sext(offset)`, modulo 2^`BITS`. `cond=0` → `count+1`.
  - CALL (100): not full → push `count+1`, `depth+1`, `count <= target`. Full → no push, `count <= count+1`, `fault <= 1`.
  - RET (101): not empty → `count <=` top entry, `depth-1`. Empty → `count <= count+1`, `fault <= 1`.
  - 110/111: illegal; `count` holds, `fault <= 1`.
- Arithmetic is unsigned modulo 2^`BITS`. The offset is sign-extended to `BITS` before the add. No carry or overflow is reported.
- `fault` is sticky. If `clr_fault` and a new fault event occur in the same cycle, set wins and `fault` stays 1.

## Timing
- Fully registered. `op`, `target`, `offset` and `cond` are sampled on the rising edge. The new `count` is visible in the same cycle after that edge (one-cycle latency).
- `depth`, `stack_full` and `stack_empty` are decoded from the registered `depth` and change on the same edge as `count`.
- `reset` asserted asynchronously, including mid-CALL/RET:
  - `count=RESET_VEC`, `depth=0`, `fault=0`, stack entries cleared to 0.
  - `stack_empty=1`, `stack_full=0`.
- Release of `reset` is synchronised externally. The first operation executes on the first rising edge with `reset=0`.
- A CALL followed immediately by a RET returns to the pushed `count+1` with no bubble.

## Structure
- Package `pc_pkg` holds:
  - `pc_op_t`, a 3-bit enum: `PC_HOLD`, `PC_INC`, `PC_JMP`, `PC_BR`, `PC_CALL`, `PC_RET`.
  - Helper function `sext_offset`.
- Sub-module `ret_stack`: a parametrised LIFO with `BITS`/`DEPTH` parameters.
  - Inputs: push/pop strobes and write data.
  - Outputs: top data, `depth`, full, empty.
  - Async reset.
  - It ignores push when full and pop when empty; the top level raises `fault`.
- The top level contains the next-address mux, the fault register and `count`.

## Test plan
- Reset behaviour (`RESET_VEC=0x10`): assert `reset` for 2 cycles mid-run after `count=0x37` → `count=0x10`, `depth=0`, `fault=0` immediately, without waiting for a clock edge.
- Increment wrap: load 0xFE via JMP, then INC, INC → `count` 0xFF, then 0x00, with `fault=0`.
- Branch, from `count=0x02` with `offset=3'b101` (−3):
  - `cond=1` → 0xFF.
  - Repeated from 0x02 with `cond=0` → 0x03.
  - From 0x7E with `offset=3'b011` → 0x81.
- Call/return: at `count=0x05`, CALL `target=0x40` → `count=0x40`, `depth=1`. Then RET → `count=0x06`, `depth=0`, `stack_empty=1`.
- Stack overflow, with `DEPTH=4`:
  - Four CALLs → `stack_full=1`.
  - A fifth CALL from 0x20 → `count=0x21`, `depth=4`, `fault=1`.
  - Four RETs return in LIFO order.
  - A fifth RET → `fault` remains 1 and `count` increments.
- Stall and clear precedence:
  - `en=0` with `op=JMP`, `target=0xAA` for 3 cycles → `count` unchanged.
  - `clr_fault=1` alone → `fault=0`.
  - `clr_fault=1` together with `op=3'b111`, `en=1` → `fault=1`, `count` held.
